// File: rtl/bsr_shift_ctrl.sv
// Sequencer for a bdShiftReg bidirectional shift register: accepts a parallel word,
// shifts it in one bit per clock, then captures and returns the register contents.
module bsr_shift_ctrl #(
    parameter int MSB = 8,
    localparam int CNT_W = $clog2(MSB + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [MSB-1:0]   cmd_data,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_len,
    output logic             sr_d,
    output logic             sr_en,
    output logic             sr_dir,
    input  logic [MSB-1:0]   sr_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [MSB-1:0]   rsp_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MSB_C = CNT_W'(MSB);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [MSB-1:0]   data_q, data_d;
    logic             dir_q, dir_d;
    logic             sr_d_q, sr_d_d;
    logic             sr_en_q, sr_en_d;
    logic             sr_dir_q, sr_dir_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [MSB-1:0]   rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0] acc_len;

    // Out-of-range lengths (0 or wider than the register) mean a full-width shift.
    function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len);
        if ((len == '0) || (len > MSB_C)) begin
            return MSB_C;
        end
        return len;
    endfunction

    // dir=0 sends the top bit of the field first; dir=1 sends bit 0 first.
    function automatic logic pick_bit(input logic [MSB-1:0]   data,
                                      input logic             dir,
                                      input logic [CNT_W-1:0] len,
                                      input logic [CNT_W-1:0] idx);
        logic [CNT_W-1:0] pos;
        pos = dir ? idx : (len - ONE_C - idx);
        return data[pos];
    endfunction

    assign acc_len = eff_len(cmd_len);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        data_d      = data_q;
        dir_d       = dir_q;
        sr_d_d      = 1'b0;
        sr_en_d     = 1'b0;
        sr_dir_d    = sr_dir_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d  = SHIFT;
                    data_d   = cmd_data;
                    dir_d    = cmd_dir;
                    len_d    = acc_len;
                    cnt_d    = '0;
                    sr_en_d  = 1'b1;
                    sr_dir_d = cmd_dir;
                    sr_d_d   = pick_bit(cmd_data, cmd_dir, acc_len, '0);
                end
            end
            SHIFT: begin
                // The counter names the bit currently on sr_d; the last one ends the burst.
                if (cnt_q == (len_q - ONE_C)) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d   = cnt_q + ONE_C;
                    sr_en_d = 1'b1;
                    sr_d_d  = pick_bit(data_q, dir_q, len_q, cnt_q + ONE_C);
                end
            end
            CAPTURE: begin
                rsp_data_d  = sr_out;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            data_q      <= '0;
            dir_q       <= 1'b0;
            sr_d_q      <= 1'b0;
            sr_en_q     <= 1'b0;
            sr_dir_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            data_q      <= data_d;
            dir_q       <= dir_d;
            sr_d_q      <= sr_d_d;
            sr_en_q     <= sr_en_d;
            sr_dir_q    <= sr_dir_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign cmd_ready = (state_q == IDLE) & ~rst;
    assign busy      = (state_q != IDLE);
    assign sr_d      = sr_d_q;
    assign sr_en     = sr_en_q;
    assign sr_dir    = sr_dir_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule
